ch_seq: RTL and testbench

- Per-channel transfer sequencer for the compression channel FIFO pair (src FIFO feeding the engine, dst FIFO draining engine output).
- On a go pulse it clears the channel, then schedules source read bursts into the src FIFO, honouring the FIFO start/stop flow-control flags.
- It tags the final source word as last, schedules destination write bursts out of the dst FIFO, and reports completion or error.
- Sits between the channel register file (descriptor count, go, abort) and the shared bus master that performs the bursts.

---
 rtl/ch_seq.sv | 213 +++++++++++++++++++++
 tb/tb_ch_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ch_seq.sv
// ch_seq: per-channel transfer sequencer for the compression src/dst FIFO pair.
// Define CH_SEQ_WATCHDOG_EN to add a stall watchdog over RUN/DRAIN.
module ch_seq #(
   parameter int unsigned BURST = 16,
   parameter int unsigned BLW   = 7,
   parameter int unsigned TO_W  = 20
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_n,
   input  logic           go,
   input  logic           abort,
   input  logic [23:0]    dc,
   output logic           m_reset,
   input  logic           src_start,
   input  logic           src_stop,
   output logic           src_req,
   input  logic           src_gnt,
   output logic [BLW-1:0] src_len,
   input  logic           src_xfer,
   output logic           src_last,
   input  logic           dst_start,
   output logic           dst_req,
   input  logic           dst_gnt,
   input  logic           dst_xfer,
   input  logic           dst_end,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [23:0]    wcnt
);

   localparam logic [BLW-1:0] BURST_L = BLW'(BURST);
   localparam logic [23:0]    BURST_W = 24'(BURST);

   typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, FIN} state_t;

   state_t         state_q, state_d;
   logic           clr_cnt_q, clr_cnt_d;
   logic [23:0]    rem_q, rem_d;
   logic           src_req_q, src_req_d;
   logic [BLW-1:0] src_len_q, src_len_d;
   logic [BLW-1:0] src_beats_q, src_beats_d;
   logic           dst_req_q, dst_req_d;
   logic [BLW-1:0] dst_beats_q, dst_beats_d;
   logic [23:0]    wcnt_q, wcnt_d;
   logic           err_q, err_d;
   logic           arst_q, arst_d;
   logic [BLW-1:0] next_len;
   logic           dst_fin;
`ifdef CH_SEQ_WATCHDOG_EN
   logic [TO_W-1:0] wd_q, wd_d;
   logic            activity;
`endif

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rem_d       = rem_q;
      src_req_d   = src_req_q;
      src_len_d   = src_len_q;
      src_beats_d = src_beats_q;
      dst_req_d   = dst_req_q;
      dst_beats_d = dst_beats_q;
      wcnt_d      = wcnt_q;
      err_d       = err_q;
      arst_d      = 1'b0;
      next_len    = (rem_q >= BURST_W) ? BURST_L : rem_q[BLW-1:0];
      dst_fin     = dst_xfer & dst_end;
`ifdef CH_SEQ_WATCHDOG_EN
      wd_d        = '0;
      activity    = src_xfer | dst_xfer | (src_gnt & src_req_q) | (dst_gnt & dst_req_q);
`endif

      if (abort) begin
         state_d = IDLE;
         if (state_q != IDLE) begin
            err_d  = 1'b1;
            arst_d = 1'b1;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (go) begin
                  if (dc != '0) begin
                     rem_d     = dc;
                     err_d     = 1'b0;
                     clr_cnt_d = 1'b0;
                     state_d   = CLR;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            CLR: begin
               wcnt_d    = '0;
               clr_cnt_d = 1'b1;
               if (clr_cnt_q) state_d = RUN;
            end
            RUN, DRAIN: begin
               // source side: request held with its length until granted
               if (src_req_q) begin
                  if (src_gnt) begin
                     src_req_d   = 1'b0;
                     src_beats_d = src_len_q;
                  end
               end else if ((src_beats_q == '0) && (rem_q != '0) && src_start && !src_stop) begin
                  src_req_d = 1'b1;
                  src_len_d = next_len;
               end
               if (src_xfer) begin
                  if (rem_q != '0) rem_d = rem_q - 24'd1;
                  if (src_beats_q != '0) src_beats_d = src_beats_q - 1'b1;
                  else err_d = 1'b1;
               end

               // destination side runs independently of the source side
               if (dst_req_q) begin
                  if (dst_gnt) begin
                     dst_req_d   = 1'b0;
                     dst_beats_d = BURST_L;
                  end
               end else if ((dst_beats_q == '0) && dst_start) begin
                  dst_req_d = 1'b1;
               end
               if (dst_xfer) begin
                  wcnt_d = wcnt_q + 24'd1;
                  if (!(dst_req_q && dst_gnt)) begin
                     if (dst_end) dst_beats_d = '0;
                     else if (dst_beats_q != '0) dst_beats_d = dst_beats_q - 1'b1;
                  end
               end

               if (dst_fin) begin
                  if (rem_q != '0) err_d = 1'b1;
                  state_d = FIN;
               end else if ((state_q == RUN) && (rem_q == '0) && (src_beats_q == '0) && !src_req_q) begin
                  state_d = DRAIN;
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase

`ifdef CH_SEQ_WATCHDOG_EN
         if ((state_q == RUN) || (state_q == DRAIN)) begin
            if (activity) begin
               wd_d = '0;
            end else if (wd_q == '1) begin
               err_d   = 1'b1;
               arst_d  = 1'b1;
               state_d = IDLE;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
`endif
      end

      // leaving the transfer states drops every request and outstanding burst
      if ((state_d != RUN) && (state_d != DRAIN)) begin
         src_req_d   = 1'b0;
         dst_req_d   = 1'b0;
         src_beats_d = '0;
         dst_beats_d = '0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q     <= IDLE;
         clr_cnt_q   <= 1'b0;
         rem_q       <= '0;
         src_req_q   <= 1'b0;
         src_len_q   <= '0;
         src_beats_q <= '0;
         dst_req_q   <= 1'b0;
         dst_beats_q <= '0;
         wcnt_q      <= '0;
         err_q       <= 1'b0;
         arst_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         rem_q       <= rem_d;
         src_req_q   <= src_req_d;
         src_len_q   <= src_len_d;
         src_beats_q <= src_beats_d;
         dst_req_q   <= dst_req_d;
         dst_beats_q <= dst_beats_d;
         wcnt_q      <= wcnt_d;
         err_q       <= err_d;
         arst_q      <= arst_d;
      end
   end

`ifdef CH_SEQ_WATCHDOG_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) wd_q <= '0;
      else           wd_q <= wd_d;
   end
`endif

   assign m_reset  = (state_q == CLR) | arst_q;
   assign src_req  = src_req_q;
   assign src_len  = src_len_q;
   assign src_last = src_xfer & (rem_q == 24'd1) & (state_q == RUN);
   assign dst_req  = dst_req_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign err      = err_q;
   assign wcnt     = wcnt_q;

endmodule

// File: tb/tb_ch_seq.sv
// Self-checking bench for ch_seq: job table, randomized jobs against a
// transaction-level master/scoreboard, plus directed corner sequences.
module tb_ch_seq;

   localparam int BURST = 16;
`ifdef CH_SEQ_WATCHDOG_EN
   localparam int TO_W_TB = 4;
`else
   localparam int TO_W_TB = 20;
`endif

   localparam int M_NORM  = 0;
   localparam int M_STOP  = 1;
   localparam int M_ABORT = 2;
   localparam int M_EARLY = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go, abort, src_start, src_stop, src_gnt, src_xfer;
   logic        dst_start, dst_gnt, dst_xfer, dst_end;
   logic [23:0] dc;
   logic        m_reset, src_req, src_last, dst_req, busy, done, err;
   logic [6:0]  src_len;
   logic [23:0] wcnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ch_seq #(.BURST(BURST), .BLW(7), .TO_W(TO_W_TB)) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n), .go(go), .abort(abort), .dc(dc),
      .m_reset(m_reset), .src_start(src_start), .src_stop(src_stop),
      .src_req(src_req), .src_gnt(src_gnt), .src_len(src_len),
      .src_xfer(src_xfer), .src_last(src_last), .dst_start(dst_start),
      .dst_req(dst_req), .dst_gnt(dst_gnt), .dst_xfer(dst_xfer),
      .dst_end(dst_end), .busy(busy), .done(done), .err(err), .wcnt(wcnt)
   );

   typedef struct {
      int dc;
      int ndst;
      int mode;
      bit rnd;
      int exp_err;
      int exp_done;
      int exp_mrst;
   } job_t;

   job_t jobs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      go = 1'b0; abort = 1'b0; src_stop = 1'b0;
      src_gnt = 1'b0; src_xfer = 1'b0; dst_gnt = 1'b0; dst_xfer = 1'b0; dst_end = 1'b0;
   endtask

   function automatic bit coin(input bit rnd);
      return !rnd || ($urandom_range(0, 2) != 0);
   endfunction

   // Bench-side bus master: grants requests, streams words, and checks the
   // sequencer against the job's word totals.
   task automatic run_job(input job_t j);
      int s_done = 0, s_gnt = 0, s_beats = 0, d_cnt = 0, d_beats = 0;
      int stop_cnt = 0, cyc = 0, done_cnt = 0, mrst_cnt = 0, exp_len;
      bit fin = 0, aborted = 0, exp_last = 0, last_d, allow;
      @(negedge clk);
      idle_inputs();
      go = 1'b1; dc = 24'(j.dc); src_start = 1'b1; dst_start = 1'b1;
      @(negedge clk);
      chk("go_err_clear", err, 0);
      chk("go_busy", busy, 1);
      while (!fin && cyc < 3000) begin
         cyc++;
         mrst_cnt += int'(m_reset);
         done_cnt += int'(done);
         idle_inputs();
         if (aborted) begin
            chk("abort_idle", busy, 0);
            chk("abort_mreset", m_reset, 1);
            chk("abort_reqs", {src_req, dst_req}, 0);
         end
         if (!busy) begin
            fin = 1;
         end else begin
            exp_last = 0;
            if (j.mode == M_ABORT && s_done == 5 && !aborted) begin
               abort = 1'b1;
               aborted = 1;
            end else begin
               if (j.rnd) begin
                  go = ($urandom_range(0, 15) == 0);
                  dc = '0;
               end
               if (dst_req && d_beats == 0) begin
                  if (coin(j.rnd)) begin dst_gnt = 1'b1; d_beats = BURST; end
               end else if (d_beats > 0 && d_cnt < j.ndst && coin(j.rnd)) begin
                  last_d = (d_cnt + 1 == j.ndst);
                  allow = !last_d || (j.mode == M_EARLY ? s_done == j.dc - 10 : s_done == j.dc);
                  if (allow) begin
                     dst_xfer = 1'b1; d_cnt++; d_beats--;
                     if (last_d) begin dst_end = 1'b1; d_beats = 0; end
                  end
               end
               if (j.mode == M_STOP && s_done == j.dc - 24 && s_beats == 0 && stop_cnt < 6) begin
                  src_stop = 1'b1;
                  stop_cnt++;
                  chk("stop_no_req", src_req, 0);
               end else if (src_req && s_beats == 0) begin
                  if (coin(j.rnd)) begin
                     exp_len = (j.dc - s_gnt > BURST) ? BURST : j.dc - s_gnt;
                     chk("src_len", src_len, exp_len);
                     src_gnt = 1'b1; s_beats = exp_len; s_gnt += exp_len;
                  end
               end else if (s_beats > 0 && !(j.mode == M_EARLY && s_done == j.dc - 10) && coin(j.rnd)) begin
                  src_xfer = 1'b1; s_beats--; s_done++;
                  exp_last = (s_done == j.dc);
               end
            end
            #1;
            if (src_xfer) chk("src_last", src_last, exp_last);
            @(negedge clk);
         end
      end
      chk("job_finished", busy, 0);
      repeat (2) begin
         @(negedge clk);
         mrst_cnt += int'(m_reset);
         done_cnt += int'(done);
      end
      chk("done_pulses", done_cnt, j.exp_done);
      chk("mreset_cycles", mrst_cnt, j.exp_mrst);
      chk("err_end", err, j.exp_err);
      chk("wcnt_end", wcnt, d_cnt);
      chk("reqs_end", {src_req, dst_req}, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int done_cnt;
      job_t rj;
      idle_inputs();
      dc = '0; src_start = 1'b0; dst_start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mreset", m_reset, 0);
      chk("rst_src_req", src_req, 0);
      chk("rst_dst_req", dst_req, 0);
      chk("rst_src_last", src_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_wcnt", wcnt, 0);
      chk("rst_src_len", src_len, 0);

      // zero-length job is rejected without touching the channel
      go = 1'b1; dc = '0;
      @(negedge clk);
      go = 1'b0;
      chk("dc0_err", err, 1);
      chk("dc0_busy", busy, 0);
      chk("dc0_mreset", m_reset, 0);
      repeat (3) begin
         @(negedge clk);
         chk("dc0_mreset_hold", m_reset, 0);
         chk("dc0_busy_hold", busy, 0);
      end

      jobs[0] = '{dc:4,  ndst:1,  mode:M_NORM,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      jobs[1] = '{dc:40, ndst:37, mode:M_NORM,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      jobs[2] = '{dc:40, ndst:20, mode:M_STOP,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      jobs[3] = '{dc:20, ndst:5,  mode:M_ABORT, rnd:0, exp_err:1, exp_done:0, exp_mrst:3};
      jobs[4] = '{dc:30, ndst:3,  mode:M_EARLY, rnd:0, exp_err:1, exp_done:1, exp_mrst:2};
      jobs[5] = '{dc:1,  ndst:1,  mode:M_NORM,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      jobs[6] = '{dc:16, ndst:16, mode:M_NORM,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      jobs[7] = '{dc:17, ndst:40, mode:M_NORM,  rnd:0, exp_err:0, exp_done:1, exp_mrst:2};
      for (int i = 0; i < 8; i++) run_job(jobs[i]);

      for (int i = 0; i < 6; i++) begin
         rj = '{dc:int'($urandom_range(1, 80)), ndst:int'($urandom_range(1, 50)),
                mode:M_NORM, rnd:1, exp_err:0, exp_done:1, exp_mrst:2};
         run_job(rj);
      end

      // stalled channel: no flow-control permission on either side
      @(negedge clk);
      idle_inputs();
      go = 1'b1; dc = 24'd4; src_start = 1'b0; dst_start = 1'b0;
      @(negedge clk);
      go = 1'b0;
      done_cnt = 0;
`ifdef CH_SEQ_WATCHDOG_EN
      for (int c = 0; c < 60 && busy; c++) begin
         @(negedge clk);
         done_cnt += int'(done);
      end
      chk("wd_idle", busy, 0);
      chk("wd_mreset", m_reset, 1);
      chk("wd_err", err, 1);
      chk("wd_no_done", done_cnt, 0);
`else
      repeat (60) begin
         @(negedge clk);
         done_cnt += int'(done);
      end
      chk("stall_busy", busy, 1);
      chk("stall_no_done", done_cnt, 0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("stall_abort_idle", busy, 0);
      chk("stall_abort_mreset", m_reset, 1);
      chk("stall_abort_err", err, 1);
`endif
      @(negedge clk);
      chk("stall_mreset_pulse", m_reset, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
